// File: rtl/aes_pkg.sv
// Shared AES types, round-count constants and inverse-cipher byte transforms.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  // 128-bit AES block; byte 0 sits in [127:120], byte k at [127-8k -: 8].
  // Column c holds bytes 4c..4c+3, row r of column c is byte 4c+r.
  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    LAST  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic block_t inv_shift_rows(input block_t b);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = b[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t b);
    block_t o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127 - 8*k -: 8] = inv_sbox(b[127 - 8*k -: 8]);
    end
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t b);
    block_t     o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[127 - 8*(4*c)     -: 8];
      a1 = b[127 - 8*(4*c + 1) -: 8];
      a2 = b[127 - 8*(4*c + 2) -: 8];
      a3 = b[127 - 8*(4*c + 3) -: 8];
      o[127 - 8*(4*c)     -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[127 - 8*(4*c + 1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[127 - 8*(4*c + 2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[127 - 8*(4*c + 3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_decrypt_rounds.sv
// Combinational inverse-cipher round datapaths shared by the iterative controller.

// Initial round: AddRoundKey only.
module DecryptInitRound
  import aes_pkg::*;
(
  input  block_t state_i,
  input  block_t rk_i,
  output block_t state_o
);
  assign state_o = state_i ^ rk_i;
endmodule

// Full inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module DecryptRound
  import aes_pkg::*;
(
  input  block_t state_i,
  input  block_t rk_i,
  output block_t state_o
);
  assign state_o = inv_mix_columns(inv_sub_bytes(inv_shift_rows(state_i)) ^ rk_i);
endmodule

// Final inverse round: as a full round but without InvMixColumns.
module DecryptLastRound
  import aes_pkg::*;
(
  input  block_t state_i,
  input  block_t rk_i,
  output block_t state_o
);
  assign state_o = inv_sub_bytes(inv_shift_rows(state_i)) ^ rk_i;
endmodule

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES inverse-cipher controller: one round per cycle, round keys
// fetched from an external store by index, valid/ready on both block ports.
module aes_decrypt_ctrl
  import aes_pkg::*;
#(
  parameter int NR       = NR_AES128,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
    $error("aes_decrypt_ctrl: NR must be 10, 12 or 14");
  end
  if (NR >= (1 << RK_IDX_W)) begin : g_bad_idx_w
    $error("aes_decrypt_ctrl: RK_IDX_W too narrow to index round key NR");
  end

  localparam logic [RK_IDX_W-1:0] RK_FIRST = RK_IDX_W'(NR);

  state_e                state_q;
  block_t                data_q;
  block_t                data_d;
  logic [RK_IDX_W-1:0]   rnd_q;
  logic [RK_IDX_W-1:0]   rk_idx_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic                  accept;
  block_t                init_out;
  block_t                round_out;
  block_t                last_out;

  DecryptInitRound u_init_round (
    .state_i (data_q),
    .rk_i    (rk_data),
    .state_o (init_out)
  );

  DecryptRound u_round (
    .state_i (data_q),
    .rk_i    (rk_data),
    .state_o (round_out)
  );

  DecryptLastRound u_last_round (
    .state_i (data_q),
    .rk_i    (rk_data),
    .state_o (last_out)
  );

  // in_ready must follow out_ready within the DONE cycle so a new block can be
  // taken on the same edge as the plaintext handshake; it cannot be registered.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign rk_idx    = rk_idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

  // Next value of the block register: round output by state, or a fresh load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    data_d = data_q;
    unique case (state_q)
      INIT:    data_d = init_out;
      ROUND:   data_d = round_out;
      LAST:    data_d = last_out;
      default: if (accept) data_d = in_data;
    endcase
  end

  // Round sequencer with registered handshake/index outputs; reset beats all.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      // NOTE: the 128-bit block register is reset because out_data mirrors it
      // and must read zero after reset.
      data_q      <= '0;
      rnd_q       <= '0;
      rk_idx_q    <= RK_FIRST;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      data_q <= data_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= INIT;
            rnd_q   <= RK_FIRST;
            busy_q  <= 1'b1;
          end
        end
        INIT: begin
          state_q  <= ROUND;
          rnd_q    <= RK_FIRST - 1'b1;
          rk_idx_q <= RK_FIRST - 1'b1;
        end
        ROUND: begin
          if (rnd_q == RK_IDX_W'(1)) begin
            state_q  <= LAST;
            rnd_q    <= '0;
            rk_idx_q <= '0;
          end else begin
            rnd_q    <= rnd_q - 1'b1;
            rk_idx_q <= rnd_q - 1'b1;
          end
        end
        LAST: begin
          state_q     <= DONE;
          rk_idx_q    <= RK_FIRST;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              state_q <= INIT;
              rnd_q   <= RK_FIRST;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
